// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file writeback arbiter.
// Imported by the arbiter core and the top-level write/scoreboard stage.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone request always wins,
// a conflict goes to the side that did not win last time.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  gnt_e last_gnt,
    output logic a_gnt,
    output logic b_gnt
);

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        unique case (1'b1)
            (a_valid & b_valid): begin
                a_gnt = (last_gnt == GNT_B);
                b_gnt = (last_gnt == GNT_A);
            end
            (a_valid & ~b_valid): a_gnt = 1'b1;
            (~a_valid & b_valid): b_gnt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// registers the winning write and tracks per-register pending reservations.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] chk_addr0,
    input  logic [ADDR_W-1:0] chk_addr1,
    output logic              chk_busy0,
    output logic              chk_busy1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    gnt_e                last_gnt_q, last_gnt_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic              a_gnt;
    logic              b_gnt;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .last_gnt (last_gnt_q),
        .a_gnt    (a_gnt),
        .b_gnt    (b_gnt)
    );

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    always_comb begin
        xfer       = a_gnt | b_gnt;
        sel_addr   = a_gnt ? a_addr : b_addr;
        sel_data   = a_gnt ? a_data : b_data;
        last_gnt_d = last_gnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pending_d  = pending_q;
        if (xfer) begin
            last_gnt_d          = a_gnt ? GNT_A : GNT_B;
            rf_we_d             = (sel_addr != REG_ZERO);
            rf_waddr_d          = sel_addr;
            rf_wdata_d          = sel_data;
            pending_d[sel_addr] = 1'b0;
        end
        // Applied after the clear so a new reservation beats the retiring write.
        if (rsv_valid && (rsv_addr != REG_ZERO)) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_B;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign chk_busy0 = pending_q[chk_addr0];
    assign chk_busy1 = pending_q[chk_addr1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a
// transaction-level model of grants, writes and reservations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, rsv_valid;
    logic [4:0]  a_addr, b_addr, rsv_addr, chk_addr0, chk_addr1;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, chk_busy0, chk_busy1;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    // Model state: last winner (1=A, 2=B), pending set, expected write.
    int          m_last;
    bit [31:0]   m_pend;
    bit          m_we;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;
    int          last_g;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_addr0 (chk_addr0),
        .chk_addr1 (chk_addr1),
        .chk_busy0 (chk_busy0),
        .chk_busy1 (chk_busy1),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 2;
        m_pend = '0;
        m_we   = 1'b0;
    endtask

    task automatic idle();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        rsv_valid = 1'b0;
    endtask

    // One cycle: inputs already driven just after a falling edge.
    task automatic step();
        int       g;
        bit [4:0] wa;
        #1;
        if (a_valid && b_valid) g = (m_last == 2) ? 1 : 2;
        else if (a_valid)       g = 1;
        else if (b_valid)       g = 2;
        else                    g = 0;
        chk("a_ready", a_ready, g == 1);
        chk("b_ready", b_ready, g == 2);
        chk("chk_busy0", chk_busy0, m_pend[chk_addr0]);
        chk("chk_busy1", chk_busy1, m_pend[chk_addr1]);
        last_g = g;
        @(posedge clk);
        m_we = 1'b0;
        if (g != 0) begin
            wa         = (g == 1) ? a_addr : b_addr;
            m_wdata    = (g == 1) ? a_data : b_data;
            m_waddr    = wa;
            m_last     = g;
            m_pend[wa] = 1'b0;
            m_we       = (wa != 0);
        end
        if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        #1;
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy0", chk_busy0, 0);
        chk("rst_busy1", chk_busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] seq [4];
        seq = '{5'd3, 5'd5, 5'd3, 5'd5};
        rst_n     = 1'b1;
        idle();
        a_addr    = '0; b_addr = '0; rsv_addr = '0;
        a_data    = '0; b_data = '0;
        chk_addr0 = 5'd7; chk_addr1 = 5'd9;
        model_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy0", chk_busy0, 0);
        chk("rst_busy1", chk_busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Conflict: A and B held for four cycles
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("conf_gnt", last_g, (i % 2 == 0) ? 1 : 2);
            chk("conf_waddr", rf_waddr, seq[i]);
        end
        idle();

        // Single A request
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hACED_CAFE;
        step();
        chk("single_we", rf_we, 1);
        chk("single_waddr", rf_waddr, 4);
        chk("single_wdata", rf_wdata, 32'hACED_CAFE);
        idle();
        step();

        // Register 0
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        step();
        chk("r0_gnt", last_g, 2);
        chk("r0_we", rf_we, 0);
        idle();
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();
        idle();
        chk_addr0 = 5'd0;
        step();
        chk("r0_busy", chk_busy0, 0);

        // Scoreboard set, clear, and set-wins
        rsv_valid = 1'b1; rsv_addr = 5'd7; chk_addr0 = 5'd7;
        step();
        idle();
        #1 chk("sb_set", chk_busy0, 1);
        #0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0077;
        step();
        idle();
        #1 chk("sb_clr", chk_busy0, 0);
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0078;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        idle();
        #1 chk("sb_setwins", chk_busy0, 1);
        step();

        // Reset mid-operation
        rsv_valid = 1'b1; rsv_addr = 5'd2;
        step();
        rsv_addr = 5'd9;
        chk_addr0 = 5'd2; chk_addr1 = 5'd9;
        step();
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h6666_6666;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h8888_8888;
        step();
        reset_pulse();
        step();
        chk("post_rst_gnt", last_g, 1);
        idle();

        // Random traffic with requesters holding until accepted
        for (int n = 0; n < 400; n++) begin
            if (!a_valid) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 5'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 5'($urandom);
                b_data  = $urandom;
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = 5'($urandom_range(0, 7));
            chk_addr0 = 5'($urandom_range(0, 7));
            chk_addr1 = 5'($urandom);
            step();
            if (last_g == 1) a_valid = 1'b0;
            if (last_g == 2) b_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
